pipe_idu: RTL and testbench

- Decode stage, directly downstream of the fetch stage.
- Accepts {pc, inst} over a valid/ready handshake and holds it in a single-entry stage register.
- Decodes RV32I fields and immediates, and tracks in-flight destination registers in a scoreboard so RAW/WAW hazards stall issue.
- Hands decoded instructions to the execute stage over a second valid/ready handshake.

---
 rtl/pipe_idu.sv | 194 +++++++++++++++++++
 tb/tb_pipe_idu.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_idu.sv
// RV32I decode stage: single-entry holding register between fetch and execute,
// field/immediate decode, and a busy-bit scoreboard that stalls RAW/WAW hazards.
module pipe_idu #(
    parameter logic [31:0] RESET_PC = 32'h80000000,
    parameter int          NREGS    = 32
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        flush_i,
    input  logic        if_valid_i,
    input  logic [31:0] if_pc_i,
    input  logic [31:0] if_inst_i,
    output logic        id_ready_o,
    output logic        id_valid_o,
    input  logic        ex_ready_i,
    output logic [31:0] id_pc_o,
    output logic [31:0] id_inst_o,
    output logic [3:0]  op_class_o,
    output logic [4:0]  rs1_o,
    output logic [4:0]  rs2_o,
    output logic [4:0]  rd_o,
    output logic        rd_wen_o,
    output logic [31:0] imm_o,
    input  logic        wb_valid_i,
    input  logic [4:0]  wb_rd_i
);

    localparam logic [3:0] CLS_ALU_R   = 4'd0;
    localparam logic [3:0] CLS_ALU_I   = 4'd1;
    localparam logic [3:0] CLS_LOAD    = 4'd2;
    localparam logic [3:0] CLS_STORE   = 4'd3;
    localparam logic [3:0] CLS_BRANCH  = 4'd4;
    localparam logic [3:0] CLS_JAL     = 4'd5;
    localparam logic [3:0] CLS_JALR    = 4'd6;
    localparam logic [3:0] CLS_LUI     = 4'd7;
    localparam logic [3:0] CLS_AUIPC   = 4'd8;
    localparam logic [3:0] CLS_SYSTEM  = 4'd9;
    localparam logic [3:0] CLS_ILLEGAL = 4'd15;

    localparam logic [31:0] NOP_INST = 32'h00000013;

    logic             valid_q, valid_d;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      inst_q, inst_d;
    logic [NREGS-1:0] busy_q, busy_d;
    logic [NREGS-1:0] busy_eff;

    logic [3:0]  op_class;
    logic [31:0] imm;
    logic        uses_rs1, uses_rs2, writes_rd;
    logic        rd_wen, hazard;
    logic        fire_in, fire_out;

    // ---------------- decode ----------------
    always_comb begin
        op_class  = CLS_ILLEGAL;
        imm       = 32'd0;
        uses_rs1  = 1'b1;
        uses_rs2  = 1'b0;
        writes_rd = 1'b0;
        case (inst_q[6:0])
            7'b0110011: begin
                op_class  = CLS_ALU_R;
                uses_rs2  = 1'b1;
                writes_rd = 1'b1;
            end
            7'b0010011: begin
                op_class  = CLS_ALU_I;
                imm       = {{20{inst_q[31]}}, inst_q[31:20]};
                writes_rd = 1'b1;
            end
            7'b0000011: begin
                op_class  = CLS_LOAD;
                imm       = {{20{inst_q[31]}}, inst_q[31:20]};
                writes_rd = 1'b1;
            end
            7'b0100011: begin
                op_class = CLS_STORE;
                imm      = {{20{inst_q[31]}}, inst_q[31:25], inst_q[11:7]};
                uses_rs2 = 1'b1;
            end
            7'b1100011: begin
                op_class = CLS_BRANCH;
                imm      = {{19{inst_q[31]}}, inst_q[31], inst_q[7],
                            inst_q[30:25], inst_q[11:8], 1'b0};
                uses_rs2 = 1'b1;
            end
            7'b1101111: begin
                op_class  = CLS_JAL;
                imm       = {{11{inst_q[31]}}, inst_q[31], inst_q[19:12],
                             inst_q[20], inst_q[30:21], 1'b0};
                uses_rs1  = 1'b0;
                writes_rd = 1'b1;
            end
            7'b1100111: begin
                op_class  = CLS_JALR;
                imm       = {{20{inst_q[31]}}, inst_q[31:20]};
                writes_rd = 1'b1;
            end
            7'b0110111: begin
                op_class  = CLS_LUI;
                imm       = {inst_q[31:12], 12'd0};
                uses_rs1  = 1'b0;
                writes_rd = 1'b1;
            end
            7'b0010111: begin
                op_class  = CLS_AUIPC;
                imm       = {inst_q[31:12], 12'd0};
                uses_rs1  = 1'b0;
                writes_rd = 1'b1;
            end
            7'b1110011: begin
                op_class = CLS_SYSTEM;
                imm      = {{20{inst_q[31]}}, inst_q[31:20]};
            end
            default: begin
                op_class = CLS_ILLEGAL;
            end
        endcase
    end

    assign rd_wen = writes_rd & (inst_q[11:7] != 5'd0);

    // ---------------- scoreboard ----------------
    genvar gi;
    generate
        for (gi = 0; gi < NREGS; gi++) begin : g_busy
            if (gi == 0) begin : g_zero
                always_comb begin
                    busy_d[gi]   = 1'b0;
                    busy_eff[gi] = 1'b0;
                end
            end else begin : g_reg
                logic set_bit, clr_bit;
                always_comb begin
                    set_bit      = fire_out & rd_wen & (inst_q[11:7] == 5'(gi));
                    clr_bit      = wb_valid_i & (wb_rd_i == 5'(gi));
                    // a same-cycle writeback already frees the register for this check
                    busy_eff[gi] = busy_q[gi] & ~clr_bit;
                    busy_d[gi]   = set_bit | busy_eff[gi];
                end
            end
        end
    endgenerate

    assign hazard = (uses_rs1 & (inst_q[19:15] != 5'd0) & busy_eff[inst_q[19:15]])
                  | (uses_rs2 & (inst_q[24:20] != 5'd0) & busy_eff[inst_q[24:20]])
                  | (rd_wen & busy_eff[inst_q[11:7]]);

    // ---------------- handshake ----------------
    assign id_valid_o = valid_q & ~hazard & ~flush_i;
    assign fire_out   = id_valid_o & ex_ready_i;
    assign id_ready_o = ~valid_q | fire_out;
    assign fire_in    = if_valid_i & id_ready_o & ~flush_i;

    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (fire_in) begin
            valid_d = 1'b1;
            pc_d    = if_pc_i;
            inst_d  = if_inst_i;
        end else if (fire_out) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            pc_q    <= RESET_PC;
            inst_q  <= NOP_INST;
            busy_q  <= '0;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            busy_q  <= busy_d;
        end
    end

    assign id_pc_o    = pc_q;
    assign id_inst_o  = inst_q;
    assign op_class_o = op_class;
    assign rs1_o      = inst_q[19:15];
    assign rs2_o      = inst_q[24:20];
    assign rd_o       = inst_q[11:7];
    assign rd_wen_o   = rd_wen;
    assign imm_o      = imm;

endmodule

// File: tb/tb_pipe_idu.sv
// Directed bench for pipe_idu: handshake, hazards, stall, flush, decode and
// asynchronous reset, each checked against hand-computed values.
module tb_pipe_idu;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        flush_i = 1'b0;
    logic        if_valid_i = 1'b0;
    logic [31:0] if_pc_i = 32'd0;
    logic [31:0] if_inst_i = 32'd0;
    logic        id_ready_o, id_valid_o;
    logic        ex_ready_i = 1'b0;
    logic [31:0] id_pc_o, id_inst_o;
    logic [3:0]  op_class_o;
    logic [4:0]  rs1_o, rs2_o, rd_o;
    logic        rd_wen_o;
    logic [31:0] imm_o;
    logic        wb_valid_i = 1'b0;
    logic [4:0]  wb_rd_i = 5'd0;

    int n_checks = 0;
    int n_fail   = 0;

    pipe_idu dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .flush_i    (flush_i),
        .if_valid_i (if_valid_i),
        .if_pc_i    (if_pc_i),
        .if_inst_i  (if_inst_i),
        .id_ready_o (id_ready_o),
        .id_valid_o (id_valid_o),
        .ex_ready_i (ex_ready_i),
        .id_pc_o    (id_pc_o),
        .id_inst_o  (id_inst_o),
        .op_class_o (op_class_o),
        .rs1_o      (rs1_o),
        .rs2_o      (rs2_o),
        .rd_o       (rd_o),
        .rd_wen_o   (rd_wen_o),
        .imm_o      (imm_o),
        .wb_valid_i (wb_valid_i),
        .wb_rd_i    (wb_rd_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end else begin
            $display("ok   %s: %08h", tag, obs);
        end
    endtask

    // advance one clock; inputs change and outputs are sampled 1ns after the edge
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic offer(input logic [31:0] pc, input logic [31:0] inst);
        if_valid_i = 1'b1;
        if_pc_i    = pc;
        if_inst_i  = inst;
    endtask

    logic [31:0] stream_pc   [4];
    logic [31:0] stream_inst [4];

    initial begin
        stream_pc[0] = 32'h8000000C; stream_inst[0] = 32'h00400213; // addi x4,x0,4
        stream_pc[1] = 32'h80000010; stream_inst[1] = 32'h00500293; // addi x5,x0,5
        stream_pc[2] = 32'h80000014; stream_inst[2] = 32'h00600313; // addi x6,x0,6
        stream_pc[3] = 32'h80000018; stream_inst[3] = 32'h00700393; // addi x7,x0,7

        // reset state
        tick(); tick();
        check_eq("rst_valid", 32'(id_valid_o), 32'd0);
        check_eq("rst_ready", 32'(id_ready_o), 32'd1);
        check_eq("rst_pc",    id_pc_o,   32'h80000000);
        check_eq("rst_inst",  id_inst_o, 32'h00000013);
        check_eq("rst_busy",  dut.busy_q, 32'd0);
        rst_i = 1'b0;
        tick();

        // addi x1,x0,5
        ex_ready_i = 1'b1;
        offer(32'h80000000, 32'h00500093);
        #1 check_eq("t1_ready", 32'(id_ready_o), 32'd1);
        tick();
        if_valid_i = 1'b0;
        #1;
        check_eq("t1_valid", 32'(id_valid_o), 32'd1);
        check_eq("t1_class", 32'(op_class_o), 32'd1);
        check_eq("t1_rd",    32'(rd_o),       32'd1);
        check_eq("t1_imm",   imm_o,           32'd5);
        check_eq("t1_rdwen", 32'(rd_wen_o),   32'd1);
        tick();
        check_eq("t1_busy1", dut.busy_q, 32'h00000002);
        check_eq("t1_empty", 32'(id_valid_o), 32'd0);

        // add x2,x1,x1 stalls on x1 until writeback
        offer(32'h80000004, 32'h00108133);
        tick();
        if_valid_i = 1'b0;
        #1;
        check_eq("raw_stall",   32'(id_valid_o), 32'd0);
        check_eq("raw_noready", 32'(id_ready_o), 32'd0);
        tick();
        check_eq("raw_stall2",  32'(id_valid_o), 32'd0);
        wb_valid_i = 1'b1; wb_rd_i = 5'd1;
        #1 check_eq("raw_release", 32'(id_valid_o), 32'd1);
        tick();
        check_eq("raw_busy", dut.busy_q, 32'h00000004);
        wb_rd_i = 5'd2;
        tick();
        wb_valid_i = 1'b0;
        #1 check_eq("wb_clear", dut.busy_q, 32'd0);

        // hold addi x3 with execute stalled for 3 cycles
        ex_ready_i = 1'b0;
        offer(32'h80000008, 32'h00100193);
        tick();
        offer(stream_pc[0], stream_inst[0]);
        for (int i = 0; i < 3; i++) begin
            #1;
            check_eq($sformatf("hold%0d_ready", i), 32'(id_ready_o), 32'd0);
            check_eq($sformatf("hold%0d_valid", i), 32'(id_valid_o), 32'd1);
            check_eq($sformatf("hold%0d_pc", i),    id_pc_o,   32'h80000008);
            check_eq($sformatf("hold%0d_inst", i),  id_inst_o, 32'h00100193);
            tick();
        end

        // release: one instruction per cycle
        ex_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            offer(stream_pc[i], stream_inst[i]);
            #1;
            check_eq($sformatf("tput%0d_fire", i), 32'(id_valid_o & id_ready_o), 32'd1);
            check_eq($sformatf("tput%0d_pc", i), id_pc_o,
                     (i == 0) ? 32'h80000008 : stream_pc[i-1]);
            tick();
        end
        if_valid_i = 1'b0;
        #1 check_eq("tput_last", id_pc_o, 32'h80000018);
        tick();
        check_eq("tput_busy", dut.busy_q, 32'h000000F8);

        // retire x4..x7, leaving x3 busy
        wb_valid_i = 1'b1;
        for (int r = 4; r < 8; r++) begin
            wb_rd_i = 5'(r);
            tick();
        end
        wb_valid_i = 1'b0;
        #1 check_eq("busy_x3", dut.busy_q, 32'h00000008);

        // WAW on x3, released by same-cycle writeback; set must win over clear
        offer(32'h80000020, 32'h00100193);
        tick();
        if_valid_i = 1'b0;
        #1 check_eq("waw_stall", 32'(id_valid_o), 32'd0);
        wb_valid_i = 1'b1; wb_rd_i = 5'd3;
        #1 check_eq("waw_release", 32'(id_valid_o), 32'd1);
        tick();
        wb_valid_i = 1'b0;
        #1 check_eq("setwins_busy", dut.busy_q, 32'h00000008);

        // flush while holding and while fetch offers
        ex_ready_i = 1'b0;
        offer(32'h00000100, 32'h00800413);
        tick();
        ex_ready_i = 1'b1;
        offer(32'h00000104, 32'h00900493);
        flush_i = 1'b1;
        #1 check_eq("flush_valid", 32'(id_valid_o), 32'd0);
        tick();
        flush_i = 1'b0;
        if_valid_i = 1'b0;
        #1;
        check_eq("flush_empty", 32'(id_valid_o), 32'd0);
        check_eq("flush_pc",    id_pc_o, 32'h00000100);
        check_eq("flush_busy",  dut.busy_q, 32'h00000008);

        // decode: beq x0,x0,-4
        offer(32'h00000200, 32'hFE000EE3);
        tick();
        if_valid_i = 1'b0;
        #1;
        check_eq("beq_class", 32'(op_class_o), 32'd4);
        check_eq("beq_imm",   imm_o, 32'hFFFFFFFC);
        check_eq("beq_rdwen", 32'(rd_wen_o), 32'd0);
        tick();

        // decode: lui x5,0x12345
        offer(32'h00000204, 32'h123452B7);
        tick();
        if_valid_i = 1'b0;
        #1;
        check_eq("lui_class", 32'(op_class_o), 32'd7);
        check_eq("lui_imm",   imm_o, 32'h12345000);
        check_eq("lui_rd",    32'(rd_o), 32'd5);
        tick();

        // decode: all-ones is illegal but still issues
        offer(32'h00000208, 32'hFFFFFFFF);
        tick();
        if_valid_i = 1'b0;
        #1;
        check_eq("ill_class", 32'(op_class_o), 32'd15);
        check_eq("ill_rdwen", 32'(rd_wen_o), 32'd0);
        check_eq("ill_valid", 32'(id_valid_o), 32'd1);
        tick();
        check_eq("dec_busy", dut.busy_q, 32'h00000028);

        // reset asserted mid-stall (add x10,x3,x0 waits on x3)
        offer(32'h0000020C, 32'h00018533);
        tick();
        if_valid_i = 1'b0;
        #1 check_eq("pre_rst_ready", 32'(id_ready_o), 32'd0);
        #2 rst_i = 1'b1;
        #1;
        check_eq("arst_valid", 32'(id_valid_o), 32'd0);
        check_eq("arst_ready", 32'(id_ready_o), 32'd1);
        check_eq("arst_busy",  dut.busy_q, 32'd0);
        check_eq("arst_pc",    id_pc_o, 32'h80000000);
        tick();
        rst_i = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
